// File: rtl/rib_watchdog.sv
// Two-stage watchdog slave on the rib bus: stage-1 interrupt, stage-2 reset-request pulse.
// Optional prescaler register at 0x14 is enabled by defining WDT_PRESCALER_EN.
module rib_watchdog #(
    parameter int unsigned RST_PULSE = 16,
    parameter logic [31:0] KICK_KEY  = 32'h5A5A_A5A5,
    parameter logic [31:0] LOAD_RST  = 32'h0010_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        ready_o,
    output logic        int_sig_o,
    output logic        rst_req_o
);
    typedef enum logic [1:0] {IDLE, ARMED, STAGE1, RESET} state_t;

    localparam logic [15:0] PULSE_LAST = 16'(RST_PULSE - 1);

    state_t      state_reg, state_next;
    logic [3:0]  ctrl_reg, ctrl_next;
    logic [31:0] load_reg, load_next;
    logic [31:0] count_reg, count_next;
    logic [1:0]  status_reg, status_next;
    logic [1:0]  status_set;
    logic [15:0] pulse_reg, pulse_next;
    logic        rst_req_reg, rst_req_next;
    logic        int_reg;
    logic        ready_reg;
    logic [31:0] data_reg;
    logic [31:0] rdata;
    logic        clr_presc;
    logic        tick;

    logic [7:0]  off;
    logic        wr, locked, kick;
    logic [1:0]  w1c;
    logic        unused_addr;

    assign off         = addr_i[7:0];
    assign wr          = req_i & we_i;
    assign locked      = ctrl_reg[3];
    assign kick        = wr && (off == 8'h0C) && (data_i == KICK_KEY);
    assign w1c         = (wr && (off == 8'h10)) ? data_i[1:0] : 2'b00;
    assign unused_addr = ^addr_i[31:8];

`ifdef WDT_PRESCALER_EN
    logic [15:0] presc_reg;
    logic [15:0] presc_cnt_reg, presc_cnt_next;
    assign tick = (presc_cnt_reg == presc_reg);
`else
    assign tick = 1'b1;
`endif

    always_comb begin
        ctrl_next = (wr && (off == 8'h00) && !locked) ? data_i[3:0] : ctrl_reg;
        load_next = (wr && (off == 8'h04) && !locked) ? data_i : load_reg;
    end

    // EN is taken from the post-write value so the counter arms on the same edge as the CTRL write.
    always_comb begin
        state_next   = state_reg;
        count_next   = count_reg;
        pulse_next   = pulse_reg;
        rst_req_next = 1'b0;
        status_set   = 2'b00;
        clr_presc    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (ctrl_next[0]) begin
                    state_next = ARMED;
                    count_next = load_reg;
                    clr_presc  = 1'b1;
                end
            end
            ARMED, STAGE1: begin
                if (!ctrl_next[0]) begin
                    state_next = IDLE;
                end else if (kick) begin
                    state_next = ARMED;
                    count_next = load_reg;
                    clr_presc  = 1'b1;
                end else if (tick) begin
                    if (count_reg == 32'd0) begin
                        clr_presc = 1'b1;
                        if (state_reg == ARMED) begin
                            status_set[0] = 1'b1;
                            count_next    = load_reg;
                            state_next    = STAGE1;
                        end else if (ctrl_reg[2]) begin
                            status_set[1] = 1'b1;
                            state_next    = RESET;
                            pulse_next    = PULSE_LAST;
                            rst_req_next  = 1'b1;
                        end else begin
                            count_next = load_reg;
                        end
                    end else begin
                        count_next = count_reg - 32'd1;
                    end
                end
            end
            RESET: begin
                if (pulse_reg == 16'd0) begin
                    state_next = ARMED;
                    count_next = load_reg;
                    clr_presc  = 1'b1;
                end else begin
                    pulse_next   = pulse_reg - 16'd1;
                    rst_req_next = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
        // A hardware set in the same cycle as a W1C clear must survive.
        status_next = (status_reg & ~w1c) | status_set;
    end

`ifdef WDT_PRESCALER_EN
    always_comb begin
        presc_cnt_next = presc_cnt_reg;
        if (clr_presc) begin
            presc_cnt_next = 16'd0;
        end else if ((state_reg == ARMED || state_reg == STAGE1) && ctrl_next[0]) begin
            presc_cnt_next = tick ? 16'd0 : presc_cnt_reg + 16'd1;
        end
    end
`endif

    always_comb begin
        case (off)
            8'h00:   rdata = {28'd0, ctrl_reg};
            8'h04:   rdata = load_reg;
            8'h08:   rdata = count_reg;
            8'h10:   rdata = {30'd0, status_reg};
`ifdef WDT_PRESCALER_EN
            8'h14:   rdata = {16'd0, presc_reg};
`endif
            default: rdata = 32'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg     <= IDLE;
            ctrl_reg      <= 4'd0;
            load_reg      <= LOAD_RST;
            count_reg     <= LOAD_RST;
            status_reg    <= 2'b00;
            pulse_reg     <= 16'd0;
            rst_req_reg   <= 1'b0;
            int_reg       <= 1'b0;
            ready_reg     <= 1'b0;
            data_reg      <= 32'd0;
`ifdef WDT_PRESCALER_EN
            presc_reg     <= 16'd0;
            presc_cnt_reg <= 16'd0;
`endif
        end else begin
            state_reg     <= state_next;
            ctrl_reg      <= ctrl_next;
            load_reg      <= load_next;
            count_reg     <= count_next;
            status_reg    <= status_next;
            pulse_reg     <= pulse_next;
            rst_req_reg   <= rst_req_next;
            int_reg       <= status_reg[0] & ctrl_reg[1];
            ready_reg     <= req_i;
            data_reg      <= (req_i && !we_i) ? rdata : 32'd0;
`ifdef WDT_PRESCALER_EN
            if (wr && (off == 8'h14) && !locked) begin
                presc_reg <= data_i[15:0];
            end
            presc_cnt_reg <= presc_cnt_next;
`endif
        end
    end

    assign data_o    = data_reg;
    assign ready_o   = ready_reg;
    assign int_sig_o = int_reg;
    assign rst_req_o = rst_req_reg;

endmodule
